// File: rtl/ex_8_2_rr_sched.sv
// ex_8_2_rr_sched
//   Round-robin scheduler that shares one ASMD datapath among NREQ
//   requesters. It grants one requester per run, pulses dp_start, follows the
//   run through dp_busy and returns the captured E/F flags with a done pulse
//   to the grantee. A watchdog aborts runs that take too long. The abort
//   pulses dp_clr to the datapath and err to the requester.
//
//   clk       in   system clock, rising edge
//   rstb      in   synchronous reset, active-high
//   req       in   [NREQ] level requests
//   gnt       out  [NREQ] one-hot grant, held for the whole run
//   done      out  [NREQ] one-cycle completion pulse to the grantee
//   res_E     out  E flag captured at the end of the last completed run
//   res_F     out  F flag captured at the end of the last completed run
//   err       out  one-cycle pulse, last run aborted on timeout
//   dp_start  out  one-cycle start pulse to the ASMD
//   dp_clr    out  one-cycle synchronous clear to the ASMD (abort only)
//   dp_busy   in   ASMD not idle
//   dp_E      in   ASMD E flag
//   dp_F      in   ASMD F flag
//
// state   | meaning
// S_IDLE  | no run active, arbitrating among req
// S_START | dp_start high for one cycle, watchdog cleared
// S_WAIT  | waiting for the ASMD to report busy
// S_RUN   | ASMD busy, waiting for it to return to idle
// S_DONE  | done pulse, flags captured
// S_ABORT | watchdog expired: done + err + dp_clr pulse

module ex_8_2_rr_sched #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 31,
   parameter int TW      = 5
) (
   input  logic            clk,
   input  logic            rstb,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic [NREQ-1:0] done,
   output logic            res_E,
   output logic            res_F,
   output logic            err,
   output logic            dp_start,
   output logic            dp_clr,
   input  logic            dp_busy,
   input  logic            dp_E,
   input  logic            dp_F
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT,
      S_RUN,
      S_DONE,
      S_ABORT
   } state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   ptr, ptr_nxt;
   logic [TW-1:0]   timer, timer_nxt;
   logic [NREQ-1:0] gnt_nxt, done_nxt;
   logic            err_nxt, dp_start_nxt, dp_clr_nxt;
   logic            res_e_nxt, res_f_nxt;

   logic [PW-1:0]   win;
   logic            found;

   // Search starts at ptr and wraps, so the requester just served is the
   // last one considered on the next arbitration.
   always_comb begin
      int            idx;
      logic [PW-1:0] cand;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         cand = PW'(idx);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      ptr_nxt      = ptr;
      timer_nxt    = timer;
      gnt_nxt      = gnt;
      done_nxt     = '0;
      err_nxt      = 1'b0;
      dp_start_nxt = 1'b0;
      dp_clr_nxt   = 1'b0;
      res_e_nxt    = res_E;
      res_f_nxt    = res_F;

      case (state)
         S_IDLE: begin
            gnt_nxt = '0;
            if (found) begin
               state_nxt    = S_START;
               gnt_nxt[win] = 1'b1;
               ptr_nxt      = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
               dp_start_nxt = 1'b1;
            end
         end
         S_START: begin
            state_nxt = S_WAIT;
            timer_nxt = '0;
         end
         S_WAIT: begin
            timer_nxt = timer + 1'b1;
            if (timer == TW'(TIMEOUT)) begin
               state_nxt  = S_ABORT;
               done_nxt   = gnt;
               err_nxt    = 1'b1;
               dp_clr_nxt = 1'b1;
            end else if (dp_busy) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            timer_nxt = timer + 1'b1;
            // watchdog is checked first: it wins over a completion seen on the same edge
            if (timer == TW'(TIMEOUT)) begin
               state_nxt  = S_ABORT;
               done_nxt   = gnt;
               err_nxt    = 1'b1;
               dp_clr_nxt = 1'b1;
            end else if (!dp_busy) begin
               state_nxt = S_DONE;
               done_nxt  = gnt;
               res_e_nxt = dp_E;
               res_f_nxt = dp_F;
            end
         end
         S_DONE, S_ABORT: begin
            state_nxt = S_IDLE;
            gnt_nxt   = '0;
         end
         default: begin
            state_nxt = S_IDLE;
            gnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstb) begin
         state    <= S_IDLE;
         ptr      <= '0;
         timer    <= '0;
         gnt      <= '0;
         done     <= '0;
         err      <= 1'b0;
         dp_start <= 1'b0;
         dp_clr   <= 1'b0;
         res_E    <= 1'b0;
         res_F    <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         timer    <= timer_nxt;
         gnt      <= gnt_nxt;
         done     <= done_nxt;
         err      <= err_nxt;
         dp_start <= dp_start_nxt;
         dp_clr   <= dp_clr_nxt;
         res_E    <= res_e_nxt;
         res_F    <= res_f_nxt;
      end
   end

endmodule

// File: tb/tb_ex_8_2_rr_sched.sv
// Bench for ex_8_2_rr_sched. A behavioural ASMD stand-in drives dp_busy/E/F.
// The stand-in starts its busy window a programmable delay after dp_start and
// keeps it for a programmable length. It can also stick busy or never rise.
// Stimulus pushes the expected outcome of each run into a queue, and a
// monitor pops it on every done pulse.

module tb_ex_8_2_rr_sched;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 31;
   localparam int TW      = 5;

   logic            clk = 1'b0;
   logic            rstb = 1'b1;
   logic [NREQ-1:0] req = '0;
   logic [NREQ-1:0] gnt, done;
   logic            res_E, res_F, err, dp_start, dp_clr;
   logic            dp_busy, dp_E, dp_F;

   ex_8_2_rr_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
      .clk(clk), .rstb(rstb), .req(req), .gnt(gnt), .done(done),
      .res_E(res_E), .res_F(res_F), .err(err), .dp_start(dp_start),
      .dp_clr(dp_clr), .dp_busy(dp_busy), .dp_E(dp_E), .dp_F(dp_F)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- ASMD stand-in ----------------
   int p_mode = 0;   // 0 normal, 1 busy stuck high, 2 busy never rises
   int p_d = 0, p_l = 1;
   bit p_e = 1'b0, p_f = 1'b0;

   logic stub_busy = 1'b0, stub_E = 1'b0, stub_F = 1'b0;
   logic armed = 1'b0, stuck = 1'b0, e_run = 1'b0, f_run = 1'b0;
   int   dly = 0, len = 0, l_run = 0;

   assign dp_busy = stub_busy;
   assign dp_E    = stub_E;
   assign dp_F    = stub_F;

   always @(posedge clk) begin
      if (dp_clr) begin
         stub_busy <= 1'b0;
         stub_E    <= 1'b0;
         stub_F    <= 1'b0;
         armed     <= 1'b0;
         stuck     <= 1'b0;
      end else if (dp_start && !stub_busy && !armed) begin
         stub_E <= 1'b0;
         stub_F <= 1'b0;
         l_run  <= p_l;
         e_run  <= p_e;
         f_run  <= p_f;
         if (p_mode == 1) begin
            stub_busy <= 1'b1;
            stuck     <= 1'b1;
         end else if (p_mode == 0) begin
            if (p_d == 0) begin
               stub_busy <= 1'b1;
               len       <= p_l;
            end else begin
               armed <= 1'b1;
               dly   <= p_d;
            end
         end
      end else if (armed) begin
         if (dly == 1) begin
            armed     <= 1'b0;
            stub_busy <= 1'b1;
            len       <= l_run;
         end else begin
            dly <= dly - 1;
         end
      end else if (stub_busy && !stuck) begin
         if (len == 1) begin
            stub_busy <= 1'b0;
            stub_E    <= e_run;
            stub_F    <= f_run;
         end else begin
            len <= len - 1;
         end
      end
   end

   // ---------------- reference model and scoreboard ----------------
   typedef struct {
      logic [NREQ-1:0] gnt;
      bit              err;
      bit              e;
      bit              f;
      int              lat;
   } exp_t;

   exp_t exp_q[$];
   exp_t mx;
   int   m_ptr = 0;
   bit   m_e = 1'b0, m_f = 1'b0;
   int   checks = 0, errors = 0;
   int   mon_starts = 0, mon_t0 = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return 0;
   endfunction

   // A run completes when the ASMD drops busy before the watchdog has counted
   // TIMEOUT cycles in WAIT/RUN. Latency is measured from the cycle where
   // dp_start is high to the cycle where done is high.
   task automatic issue(input logic [NREQ-1:0] r, input int mode, input int d,
                        input int l, input bit e, input bit f, input bit push);
      exp_t x;
      int   w;
      bit   ok;
      p_mode = mode; p_d = d; p_l = l; p_e = e; p_f = f;
      req = r;
      w = pick(r, m_ptr);
      ok = (mode == 0) && (d + l + 1 <= TIMEOUT);
      x.gnt = '0;
      x.gnt[w] = 1'b1;
      x.err = !ok;
      if (ok) begin
         m_e = e;
         m_f = f;
      end
      x.e = m_e;
      x.f = m_f;
      x.lat = ok ? d + l + 2 : TIMEOUT + 2;
      if (push) exp_q.push_back(x);
      m_ptr = (w + 1) % NREQ;
   endtask

   task automatic wait_done(input bit scramble);
      int n = 0;
      bit seen = 1'b0;
      do begin
         @(negedge clk);
         n++;
         if (dp_start) seen = 1'b1;
         else if (seen && scramble && $urandom_range(0, 3) == 0)
            req = NREQ'($urandom);
      end while (done == '0 && n < 200);
      if (done == '0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done within %0d cycles, required a done pulse", n);
      end
   endtask

   task automatic do_reset();
      req = '0;
      rstb = 1'b1;
      @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_start", dp_start, 0);
      chk("rst_clr", dp_clr, 0);
      chk("rst_res", {res_E, res_F}, 0);
      rstb = 1'b0;
      m_ptr = 0;
      m_e = 1'b0;
      m_f = 1'b0;
      mon_starts = 0;
   endtask

   // monitor
   initial begin
      forever begin
         @(negedge clk);
         chk("gnt_onehot", ((gnt & (gnt - 1'b1)) == '0), 1);
         if (dp_start) begin
            mon_starts++;
            mon_t0 = cyc;
         end
         if (err && done == '0) chk("err_without_done", err, 0);
         if (done != '0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", done, 0);
            end else begin
               mx = exp_q.pop_front();
               chk("done_grantee", done, mx.gnt);
               chk("gnt_during_done", gnt, mx.gnt);
               chk("err", err, mx.err);
               chk("dp_clr", dp_clr, mx.err);
               chk("res_E", res_E, mx.e);
               chk("res_F", res_F, mx.f);
               chk("latency", cyc - mon_t0, mx.lat);
               chk("start_pulses", mon_starts, 1);
               mon_starts = 0;
            end
         end
      end
   end

   // stimulus
   initial begin
      int n;
      rstb = 1'b1;
      repeat (2) @(negedge clk);
      do_reset();

      // single requester, completion with E=F=1
      issue(4'b0001, 0, 0, 13, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk("t1_gnt", gnt, 4'b0001);
      chk("t1_start", dp_start, 1);
      wait_done(1'b0);

      // two simultaneous requesters from reset
      do_reset();
      issue(4'b1010, 0, 1, 6, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      chk("t2_first_gnt", gnt, 4'b0010);
      wait_done(1'b1);
      issue(4'b1010, 0, 0, 4, 1'b1, 1'b0, 1'b1);
      wait_done(1'b0);

      // all requesting: strict rotation
      for (int i = 0; i < 8; i++) begin
         issue(4'b1111, 0, $urandom_range(0, 2), $urandom_range(1, 10),
               1'($urandom), 1'($urandom), 1'b1);
         wait_done(1'b0);
      end

      // busy stuck high, then busy never rising
      issue(4'b0100, 1, 0, 1, 1'b0, 1'b0, 1'b1);
      wait_done(1'b0);
      issue(4'b0110, 2, 0, 1, 1'b1, 1'b1, 1'b1);
      wait_done(1'b0);

      // watchdog boundary
      issue(4'b0001, 0, 0, 30, 1'b1, 1'b0, 1'b1);
      wait_done(1'b0);
      issue(4'b0011, 0, 0, 31, 1'b0, 1'b1, 1'b1);
      wait_done(1'b0);
      issue(4'b1000, 0, 1, 30, 1'b0, 1'b0, 1'b1);
      wait_done(1'b0);
      issue(4'b0101, 0, 0, 1, 1'b0, 1'b1, 1'b1);
      wait_done(1'b0);

      // randomized runs
      for (int i = 0; i < 40; i++) begin
         issue(NREQ'($urandom_range(1, 15)),
               ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0,
               $urandom_range(0, 3), $urandom_range(1, 32),
               1'($urandom), 1'($urandom), 1'b1);
         wait_done(1'b1);
      end

      // reset in the middle of a run
      issue(4'b0010, 0, 0, 20, 1'b1, 1'b1, 1'b0);
      repeat (8) @(negedge clk);
      chk("t6_busy_before_reset", dp_busy, 1);
      do_reset();
      n = 0;
      while (dp_busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("t6_asmd_idle", dp_busy, 0);
      issue(4'b1100, 0, 0, 3, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("t6_gnt_after_reset", gnt, 4'b0100);
      wait_done(1'b0);

      repeat (3) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
